// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes on both sides. Shifts run
// iteratively at SHIFT_STEP bits per cycle; result and flags are registered.
module alu_multicycle #(
    parameter int N          = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    localparam int             W      = $clog2(N);
    localparam logic [W-1:0]   STEP_W = W'(SHIFT_STEP);

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [N-1:0]   work_r;
    logic [W-1:0]   remaining_r;
    logic [3:0]     kind_r;
    logic [N-1:0]   result_r;
    logic           overflow_r;
    logic           zero_r;
    logic           equal_r;
    logic           out_valid_r;

    logic [N-1:0]   alu_res_s;
    logic           alu_ovf_s;
    logic           is_shift_s;
    logic [W-1:0]   shamt_s;
    logic [W-1:0]   step_s;
    logic [N-1:0]   shifted_s;

    assign shamt_s   = b[W-1:0];
    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;
    assign equal     = equal_r;

    // Single-cycle datapath on the operands presented at accept; shifts pass a through (shamt==0 case)
    always_comb begin
        alu_res_s  = {N{1'b0}};
        alu_ovf_s  = 1'b0;
        is_shift_s = 1'b0;
        case (control)
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_NOR:  alu_res_s = ~(a | b);
            OP_ADD: begin
                alu_res_s = a + b;
                alu_ovf_s = (a[N-1] == b[N-1]) && (alu_res_s[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res_s = a - b;
                alu_ovf_s = (a[N-1] != b[N-1]) && (alu_res_s[N-1] != a[N-1]);
            end
            OP_SLT:  alu_res_s = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res_s = {{(N-1){1'b0}}, (a < b)};
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res_s  = a;
                is_shift_s = 1'b1;
            end
            default: alu_res_s = {N{1'b0}};
        endcase
    end

    // One iterative shift step: min(SHIFT_STEP, remaining) bits in the latched direction
    always_comb begin
        step_s    = (remaining_r < STEP_W) ? remaining_r : STEP_W;
        shifted_s = work_r;
        case (kind_r)
            OP_SLL:  shifted_s = work_r << step_s;
            OP_SRL:  shifted_s = work_r >> step_s;
            OP_SRA:  shifted_s = $unsigned($signed(work_r) >>> step_s);
            default: shifted_s = work_r;
        endcase
    end

    // Control FSM and all registered outputs; result/flags only change on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            work_r      <= {N{1'b0}};
            remaining_r <= {W{1'b0}};
            kind_r      <= 4'h0;
            result_r    <= {N{1'b0}};
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            equal_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        equal_r <= (a == b);
                        if (is_shift_s && (shamt_s != {W{1'b0}})) begin
                            work_r      <= a;
                            remaining_r <= shamt_s;
                            kind_r      <= control;
                            state_r     <= BUSY;
                        end else begin
                            result_r    <= alu_res_s;
                            overflow_r  <= alu_ovf_s;
                            zero_r      <= (alu_res_s == {N{1'b0}});
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    work_r      <= shifted_s;
                    remaining_r <= remaining_r - step_s;
                    if (remaining_r == step_s) begin
                        result_r    <= shifted_s;
                        overflow_r  <= 1'b0;
                        zero_r      <= (shifted_s == {N{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, multi-cycle corner cases,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int N_RANDOM_TESTS = 20;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hC;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  control;
    logic        overflow, zero, equal;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] result4;
    logic        overflow4, zero4, equal4;

    int errors = 0;
    int checks = 0;

    alu_multicycle #(.N(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow),
        .zero(zero), .equal(equal)
    );

    alu_multicycle #(.N(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .control(control), .out_valid(out_valid4),
        .out_ready(out_ready4), .result(result4), .overflow(overflow4),
        .zero(zero4), .equal(equal4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        o;
        int          lat;
    } mres_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [31:0] r;
        logic        o;
        logic        z;
        logic        e;
        int          lat;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, shifts by the shift operators directly
    function automatic mres_t model(input logic [31:0] x, input logic [31:0] y,
                                    input logic [3:0] c, input int step);
        mres_t  m;
        longint s;
        longint lim;
        int     sh;
        m.r = 32'h0;
        m.o = 1'b0;
        m.lat = 1;
        lim = 64'sh7FFF_FFFF;
        sh = int'(y[4:0]);
        case (c)
            OP_AND:  m.r = x & y;
            OP_OR:   m.r = x | y;
            OP_XOR:  m.r = x ^ y;
            OP_NOR:  m.r = ~(x | y);
            OP_ADD: begin
                s = longint'($signed(x)) + longint'($signed(y));
                m.r = s[31:0];
                m.o = (s > lim) || (s < -lim - 64'sd1);
            end
            OP_SUB: begin
                s = longint'($signed(x)) - longint'($signed(y));
                m.r = s[31:0];
                m.o = (s > lim) || (s < -lim - 64'sd1);
            end
            OP_SLT:  m.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: m.r = (x < y) ? 32'd1 : 32'd0;
            OP_SLL:  m.r = x << sh;
            OP_SRL:  m.r = x >> sh;
            OP_SRA:  m.r = $unsigned($signed(x) >>> sh);
            default: m.r = 32'h0;
        endcase
        if ((c == OP_SLL || c == OP_SRL || c == OP_SRA) && sh != 0)
            m.lat = 1 + (sh + step - 1) / step;
        return m;
    endfunction

    // Issue one op on dut, measure latency, hold under backpressure, then pop
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [3:0] tc, input logic [31:0] er, input logic eo,
                          input logic ez, input logic eq, input int elat,
                          input int hold, input bit noise);
        int lat;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " in_ready before"}, in_ready, 1);
        a = ta; b = tb_v; control = tc; in_valid = 1'b1;
        out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                a = $urandom; b = $urandom; control = 4'($urandom);
                in_valid = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " result"}, result, er);
        chk({tag, " overflow"}, overflow, eo);
        chk({tag, " zero"}, zero, ez);
        chk({tag, " equal"}, equal, eq);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (noise) begin
                a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk({tag, " held out_valid"}, out_valid, 1);
            chk({tag, " held result"}, result, er);
            chk({tag, " held in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, " popped out_valid"}, out_valid, 0);
        chk({tag, " popped in_ready"}, in_ready, 1);
    endtask

    vec_t  tbl[11];
    mres_t m;
    logic [3:0] ops[11];
    logic [31:0] ra, rb;
    int lat4;

    initial begin
        tbl[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,  32'h8000_0000, 1'b1, 1'b0, 1'b0, 1,  0};
        tbl[1]  = '{32'h1234_5678, 32'h1234_5678, OP_SUB,  32'h0000_0000, 1'b0, 1'b1, 1'b1, 1,  0};
        tbl[2]  = '{32'h0000_0001, 32'h0000_0020, OP_SLL,  32'h0000_0001, 1'b0, 1'b0, 1'b0, 1,  0};
        tbl[3]  = '{32'h0000_0001, 32'hFFFF_FFFF, OP_SLTU, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1,  5};
        tbl[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, OP_SLT,  32'h0000_0001, 1'b0, 1'b0, 1'b0, 1,  0};
        tbl[5]  = '{32'hF000_0000, 32'h0000_0004, OP_SRL,  32'h0F00_0000, 1'b0, 1'b0, 1'b0, 5,  1};
        tbl[6]  = '{32'h0000_0005, 32'h0000_0005, 4'hF,    32'h0000_0000, 1'b0, 1'b1, 1'b1, 1,  0};
        tbl[7]  = '{32'h8000_0000, 32'h0000_0001, OP_SUB,  32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1,  0};
        tbl[8]  = '{32'h8000_0000, 32'h0000_001F, OP_SRA,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32, 0};
        tbl[9]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND,  32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1,  0};
        tbl[10] = '{32'hFFFF_FFFF, 32'h0000_0001, OP_ADD,  32'h0000_0000, 1'b0, 1'b1, 1'b0, 1,  0};

        rst = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b1;
        a = 32'h0; b = 32'h0; control = 4'h0;
        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset overflow", overflow, 0);
        chk("reset zero", zero, 0);
        chk("reset equal", equal, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r,
                   tbl[i].o, tbl[i].z, tbl[i].e, tbl[i].lat, tbl[i].hold, 1'b0);

        // Same SRA on the 4-bit-per-cycle instance: ceil(31/4) = 8 BUSY cycles
        a = 32'h8000_0000; b = 32'h0000_001F; control = OP_SRA; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat4 = 1;
        while (!out_valid4 && lat4 < 100) begin
            @(negedge clk);
            lat4++;
        end
        chk("step4 sra latency", lat4, 9);
        chk("step4 sra result", result4, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("step4 popped", out_valid4, 0);

        // Reset in the middle of a long SRL: the op must vanish
        a = 32'hFFFF_FFFF; b = 32'h0000_0010; control = OP_SRL; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy in_ready", in_ready, 0);
        rst = 1'b0;
        #2;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst result", result, 0);
        chk("midrst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("postrst out_valid", out_valid, 0);
        end
        chk("postrst in_ready", in_ready, 1);
        run_op("postrst add", 32'd3, 32'd4, OP_ADD, 32'd7, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);

        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU,
                OP_SLL, OP_SRL, OP_SRA};
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < N_RANDOM_TESTS; k++) begin
                ra = $urandom;
                rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
                m = model(ra, rb, ops[i], 1);
                run_op($sformatf("rnd op%0h #%0d", ops[i], k), ra, rb, ops[i], m.r, m.o,
                       (m.r == 32'h0), (ra == rb), m.lat, int'($urandom_range(0, 2)), 1'b1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom;
            m = model(ra, rb, 4'hA + 4'(k & 1), 1);
            run_op("rnd undef", ra, rb, 4'hA + 4'(k & 1), m.r, m.o, (m.r == 32'h0),
                   (ra == rb), m.lat, 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
